// File: rtl/cache_dma_responder.sv
`default_nettype none
// ============================================================================
// Module   : cache_dma_responder
// Purpose  : Memory-side DMA responder for the last-level cache. Serialises
//            block evictions into word writes and assembles block fills from
//            word reads on a simple req/ack memory port.
// Ports    : clk_i, rst_i             - clock, async active-high reset
//            request_i/addr_request_i - fill request from the cache
//            data_request_o/addr_request_o/request_valid_o - fill response
//            evict_req_i/data_evict_i/addr_evict_i/evict_ack_o - eviction
//            mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o/mem_rdata_i/mem_ack_i
//                                     - word-wide memory port
// Revision : 1.0 - initial release
// ============================================================================
module cache_dma_responder #(
    parameter int BLOCK_BITS = 512,
    parameter int WORD_BITS  = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  request_i,
    input  logic [31:0]           addr_request_i,
    output logic [BLOCK_BITS-1:0] data_request_o,
    output logic [31:0]           addr_request_o,
    output logic                  request_valid_o,
    input  logic                  evict_req_i,
    input  logic [BLOCK_BITS-1:0] data_evict_i,
    input  logic [31:0]           addr_evict_i,
    output logic                  evict_ack_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [31:0]           mem_addr_o,
    output logic [WORD_BITS-1:0]  mem_wdata_o,
    input  logic [WORD_BITS-1:0]  mem_rdata_i,
    input  logic                  mem_ack_i
);

    localparam int              WORDS      = BLOCK_BITS / WORD_BITS;
    localparam int              CNT_W      = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int              WORD_BYTES = WORD_BITS / 8;
    localparam logic [31:0]     ALIGN_MASK = ~(32'(BLOCK_BITS / 8) - 32'd1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_EVICT_WR  = 3'd1,
        S_EVICT_ACK = 3'd2,
        S_FILL_RD   = 3'd3,
        S_FILL_RESP = 3'd4
    } state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [31:0]           r_base;
    logic [BLOCK_BITS-1:0] r_evict_buf;
    logic [BLOCK_BITS-1:0] r_fill_buf;

    logic [CNT_W-1:0]      w_cnt_inc;
    logic [31:0]           w_next_addr;
    logic [WORD_BITS-1:0]  w_next_wdata;
    logic [BLOCK_BITS-1:0] w_fill_next;

    // Memory outputs are registered, so the values for the following beat are
    // prepared from the incremented counter when the current beat is acked.
    assign w_cnt_inc    = r_cnt + CNT_W'(1);
    assign w_next_addr  = r_base + (32'(w_cnt_inc) * 32'(WORD_BYTES));
    assign w_next_wdata = r_evict_buf[w_cnt_inc*WORD_BITS +: WORD_BITS];

    // Fill buffer with the word arriving this cycle merged in; used both to
    // update the buffer and to publish the complete block on the last beat.
    always_comb begin
        w_fill_next = r_fill_buf;
        w_fill_next[r_cnt*WORD_BITS +: WORD_BITS] = mem_rdata_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state         <= S_IDLE;
            r_cnt           <= '0;
            r_base          <= '0;
            r_evict_buf     <= '0;
            r_fill_buf      <= '0;
            data_request_o  <= '0;
            addr_request_o  <= '0;
            request_valid_o <= 1'b0;
            evict_ack_o     <= 1'b0;
            mem_req_o       <= 1'b0;
            mem_we_o        <= 1'b0;
            mem_addr_o      <= '0;
            mem_wdata_o     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Eviction wins so a dirty victim is written back before
                    // its replacement block is fetched.
                    if (evict_req_i) begin
                        r_evict_buf <= data_evict_i;
                        r_base      <= addr_evict_i & ALIGN_MASK;
                        r_cnt       <= '0;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= 1'b1;
                        mem_addr_o  <= addr_evict_i & ALIGN_MASK;
                        mem_wdata_o <= data_evict_i[WORD_BITS-1:0];
                        r_state     <= S_EVICT_WR;
                    end else if (request_i) begin
                        r_base      <= addr_request_i & ALIGN_MASK;
                        r_cnt       <= '0;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= 1'b0;
                        mem_addr_o  <= addr_request_i & ALIGN_MASK;
                        mem_wdata_o <= '0;
                        r_state     <= S_FILL_RD;
                    end
                end

                S_EVICT_WR: begin
                    if (mem_ack_i) begin
                        if (r_cnt == LAST_BEAT) begin
                            mem_req_o   <= 1'b0;
                            mem_we_o    <= 1'b0;
                            mem_addr_o  <= '0;
                            mem_wdata_o <= '0;
                            evict_ack_o <= 1'b1;
                            r_state     <= S_EVICT_ACK;
                        end else begin
                            r_cnt       <= w_cnt_inc;
                            mem_addr_o  <= w_next_addr;
                            mem_wdata_o <= w_next_wdata;
                        end
                    end
                end

                S_EVICT_ACK: begin
                    evict_ack_o <= 1'b0;
                    r_state     <= S_IDLE;
                end

                S_FILL_RD: begin
                    if (mem_ack_i) begin
                        r_fill_buf <= w_fill_next;
                        if (r_cnt == LAST_BEAT) begin
                            mem_req_o       <= 1'b0;
                            mem_addr_o      <= '0;
                            data_request_o  <= w_fill_next;
                            addr_request_o  <= r_base;
                            request_valid_o <= 1'b1;
                            r_state         <= S_FILL_RESP;
                        end else begin
                            r_cnt      <= w_cnt_inc;
                            mem_addr_o <= w_next_addr;
                        end
                    end
                end

                S_FILL_RESP: begin
                    request_valid_o <= 1'b0;
                    r_state         <= S_IDLE;
                end

                default: begin
                    mem_req_o       <= 1'b0;
                    mem_we_o        <= 1'b0;
                    evict_ack_o     <= 1'b0;
                    request_valid_o <= 1'b0;
                    r_state         <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_dma_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_dma_responder
// Purpose  : Directed self-checking bench for cache_dma_responder. The bench
//            acts as both the cache and the memory, driving inputs on the
//            falling clock edge and checking outputs there as well.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_dma_responder;

    localparam int BLOCK_BITS = 512;
    localparam int WORD_BITS  = 32;
    localparam int WORDS      = BLOCK_BITS / WORD_BITS;

    logic                  clk_i = 1'b0;
    logic                  rst_i;
    logic                  request_i;
    logic [31:0]           addr_request_i;
    logic [BLOCK_BITS-1:0] data_request_o;
    logic [31:0]           addr_request_o;
    logic                  request_valid_o;
    logic                  evict_req_i;
    logic [BLOCK_BITS-1:0] data_evict_i;
    logic [31:0]           addr_evict_i;
    logic                  evict_ack_o;
    logic                  mem_req_o;
    logic                  mem_we_o;
    logic [31:0]           mem_addr_o;
    logic [WORD_BITS-1:0]  mem_wdata_o;
    logic [WORD_BITS-1:0]  mem_rdata_i;
    logic                  mem_ack_i;

    int n_cmp = 0;
    int n_err = 0;

    cache_dma_responder #(.BLOCK_BITS(BLOCK_BITS), .WORD_BITS(WORD_BITS)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .request_i       (request_i),
        .addr_request_i  (addr_request_i),
        .data_request_o  (data_request_o),
        .addr_request_o  (addr_request_o),
        .request_valid_o (request_valid_o),
        .evict_req_i     (evict_req_i),
        .data_evict_i    (data_evict_i),
        .addr_evict_i    (addr_evict_i),
        .evict_ack_o     (evict_ack_o),
        .mem_req_o       (mem_req_o),
        .mem_we_o        (mem_we_o),
        .mem_addr_o      (mem_addr_o),
        .mem_wdata_o     (mem_wdata_o),
        .mem_rdata_i     (mem_rdata_i),
        .mem_ack_i       (mem_ack_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Expected block whose word k is pat+k.
    function automatic logic [BLOCK_BITS-1:0] make_block(input logic [31:0] pat);
        logic [BLOCK_BITS-1:0] b;
        b = '0;
        for (int k = 0; k < WORDS; k++) b[k*WORD_BITS +: WORD_BITS] = pat + 32'(k);
        return b;
    endfunction

    // Acts as memory for read beats first..last; on entry the bench sits in
    // the cycle where beat 'first' is presented. Returns with ack low.
    task automatic serve_fill(input logic [31:0] base, input logic [31:0] pat,
                              input int wait_n, input int first, input int last);
        logic [31:0] ea;
        for (int k = first; k <= last; k++) begin
            ea = base + 32'(4 * k);
            for (int w = 0; w <= wait_n; w++) begin
                n_cmp++;
                if (mem_req_o !== 1'b1 || mem_we_o !== 1'b0 || mem_addr_o !== ea || request_valid_o !== 1'b0) begin
                    n_err++;
                    $display("FAIL fill_beat%0d: req=%b we=%b addr=%h valid=%b, expected req=1 we=0 addr=%h valid=0",
                             k, mem_req_o, mem_we_o, mem_addr_o, request_valid_o, ea);
                end
                mem_ack_i   = (w == wait_n);
                mem_rdata_i = (w == wait_n) ? pat + 32'(k) : 32'hDEAD_BEEF;
                @(negedge clk_i);
            end
        end
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
    endtask

    task automatic serve_evict(input logic [31:0] base, input logic [31:0] pat, input int wait_n);
        logic [31:0] ea;
        for (int k = 0; k < WORDS; k++) begin
            ea = base + 32'(4 * k);
            for (int w = 0; w <= wait_n; w++) begin
                n_cmp++;
                if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1 || mem_addr_o !== ea ||
                    mem_wdata_o !== pat + 32'(k) || evict_ack_o !== 1'b0) begin
                    n_err++;
                    $display("FAIL evict_beat%0d: req=%b we=%b addr=%h wdata=%h ack=%b, expected req=1 we=1 addr=%h wdata=%h ack=0",
                             k, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, evict_ack_o, ea, pat + 32'(k));
                end
                mem_ack_i = (w == wait_n);
                @(negedge clk_i);
            end
        end
        mem_ack_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; request_i = 1'b0; addr_request_i = '0; evict_req_i = 1'b0;
        data_evict_i = '0; addr_evict_i = '0; mem_rdata_i = '0; mem_ack_i = 1'b0;
        repeat (3) @(negedge clk_i);
        n_cmp++;
        if (mem_req_o !== 1'b0 || mem_we_o !== 1'b0 || mem_addr_o !== 32'h0 || mem_wdata_o !== 32'h0 ||
            request_valid_o !== 1'b0 || evict_ack_o !== 1'b0 || addr_request_o !== 32'h0 || data_request_o !== '0) begin
            n_err++;
            $display("FAIL reset_state: req=%b we=%b addr=%h wdata=%h valid=%b ack=%b raddr=%h, expected all zero",
                     mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, request_valid_o, evict_ack_o, addr_request_o);
        end
        rst_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic test_fill();
        logic [BLOCK_BITS-1:0] exp_blk;
        exp_blk = make_block(32'hA000_0000);
        request_i = 1'b1; addr_request_i = 32'h0000_1234;
        @(negedge clk_i);
        serve_fill(32'h0000_1200, 32'hA000_0000, 0, 0, WORDS - 1);
        n_cmp++;
        if (request_valid_o !== 1'b1 || addr_request_o !== 32'h0000_1200) begin
            n_err++;
            $display("FAIL fill_resp: valid=%b addr=%h, expected valid=1 addr=00001200", request_valid_o, addr_request_o);
        end
        n_cmp++;
        if (data_request_o[31:0] !== 32'hA000_0000 || data_request_o[511:480] !== 32'hA000_000F) begin
            n_err++;
            $display("FAIL fill_words: w0=%h w15=%h, expected w0=a0000000 w15=a000000f",
                     data_request_o[31:0], data_request_o[511:480]);
        end
        n_cmp++;
        if (data_request_o !== exp_blk) begin
            n_err++;
            $display("FAIL fill_block: got %h expected %h", data_request_o, exp_blk);
        end
        request_i = 1'b0;
        @(negedge clk_i);
        n_cmp++;
        if (request_valid_o !== 1'b0 || mem_req_o !== 1'b0 || data_request_o !== exp_blk) begin
            n_err++;
            $display("FAIL fill_after: valid=%b req=%b, expected valid=0 req=0 with block held", request_valid_o, mem_req_o);
        end
    endtask

    task automatic test_evict();
        evict_req_i = 1'b1; addr_evict_i = 32'h0000_4040;
        data_evict_i = make_block(32'hE000_0000);
        @(negedge clk_i);
        serve_evict(32'h0000_4040, 32'hE000_0000, 3);
        n_cmp++;
        if (evict_ack_o !== 1'b1 || mem_req_o !== 1'b0) begin
            n_err++;
            $display("FAIL evict_ack: ack=%b req=%b, expected ack=1 req=0", evict_ack_o, mem_req_o);
        end
        evict_req_i = 1'b0; data_evict_i = '0;
        @(negedge clk_i);
        n_cmp++;
        if (evict_ack_o !== 1'b0 || mem_req_o !== 1'b0) begin
            n_err++;
            $display("FAIL evict_single: ack=%b req=%b, expected ack=0 req=0", evict_ack_o, mem_req_o);
        end
    endtask

    task automatic test_priority();
        evict_req_i = 1'b1; addr_evict_i = 32'h0000_4040; data_evict_i = make_block(32'h5500_0000);
        request_i   = 1'b1; addr_request_i = 32'h0000_8010;
        @(negedge clk_i);
        serve_evict(32'h0000_4040, 32'h5500_0000, 0);
        n_cmp++;
        if (evict_ack_o !== 1'b1 || mem_req_o !== 1'b0 || request_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL prio_ack: ack=%b req=%b valid=%b, expected ack=1 req=0 valid=0",
                     evict_ack_o, mem_req_o, request_valid_o);
        end
        evict_req_i = 1'b0;
        @(negedge clk_i);
        n_cmp++;
        if (evict_ack_o !== 1'b0 || mem_req_o !== 1'b0) begin
            n_err++;
            $display("FAIL prio_idle: ack=%b req=%b, expected ack=0 req=0", evict_ack_o, mem_req_o);
        end
        @(negedge clk_i);
        serve_fill(32'h0000_8000, 32'hC000_0000, 1, 0, WORDS - 1);
        n_cmp++;
        if (request_valid_o !== 1'b1 || addr_request_o !== 32'h0000_8000 || data_request_o !== make_block(32'hC000_0000)) begin
            n_err++;
            $display("FAIL prio_fill: valid=%b addr=%h w0=%h, expected valid=1 addr=00008000 w0=c0000000",
                     request_valid_o, addr_request_o, data_request_o[31:0]);
        end
        request_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic test_reset_mid_fill();
        request_i = 1'b1; addr_request_i = 32'h0000_2400;
        @(negedge clk_i);
        serve_fill(32'h0000_2400, 32'h1100_0000, 0, 0, 5);
        request_i = 1'b0;
        rst_i = 1'b1;
        #1;
        n_cmp++;
        if (mem_req_o !== 1'b0 || mem_addr_o !== 32'h0 || request_valid_o !== 1'b0 ||
            addr_request_o !== 32'h0 || data_request_o !== '0) begin
            n_err++;
            $display("FAIL abort_outputs: req=%b addr=%h valid=%b raddr=%h, expected all zero",
                     mem_req_o, mem_addr_o, request_valid_o, addr_request_o);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        n_cmp++;
        if (request_valid_o !== 1'b0 || mem_req_o !== 1'b0) begin
            n_err++;
            $display("FAIL abort_quiet: valid=%b req=%b, expected valid=0 req=0", request_valid_o, mem_req_o);
        end
        request_i = 1'b1; addr_request_i = 32'h0000_3000;
        @(negedge clk_i);
        serve_fill(32'h0000_3000, 32'hB000_0000, 0, 0, WORDS - 1);
        n_cmp++;
        if (request_valid_o !== 1'b1 || addr_request_o !== 32'h0000_3000 || data_request_o !== make_block(32'hB000_0000)) begin
            n_err++;
            $display("FAIL abort_refill: valid=%b addr=%h w0=%h, expected valid=1 addr=00003000 w0=b0000000",
                     request_valid_o, addr_request_o, data_request_o[31:0]);
        end
        request_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic test_ignore_inputs();
        mem_ack_i = 1'b1;
        repeat (2) @(negedge clk_i);
        mem_ack_i = 1'b0;
        n_cmp++;
        if (mem_req_o !== 1'b0 || request_valid_o !== 1'b0 || evict_ack_o !== 1'b0) begin
            n_err++;
            $display("FAIL idle_ack: req=%b valid=%b ack=%b, expected all 0", mem_req_o, request_valid_o, evict_ack_o);
        end
        request_i = 1'b1; addr_request_i = 32'h0000_207F;
        @(negedge clk_i);
        serve_fill(32'h0000_2040, 32'h7700_0000, 0, 0, 3);
        addr_request_i = 32'hDEAD_0000;
        serve_fill(32'h0000_2040, 32'h7700_0000, 2, 4, WORDS - 1);
        n_cmp++;
        if (request_valid_o !== 1'b1 || addr_request_o !== 32'h0000_2040 || data_request_o !== make_block(32'h7700_0000)) begin
            n_err++;
            $display("FAIL latched_addr: valid=%b addr=%h, expected valid=1 addr=00002040", request_valid_o, addr_request_o);
        end
        request_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic test_back_to_back();
        request_i = 1'b1; addr_request_i = 32'h0001_0000;
        @(negedge clk_i);
        serve_fill(32'h0001_0000, 32'h3300_0000, 0, 0, WORDS - 1);
        n_cmp++;
        if (request_valid_o !== 1'b1 || addr_request_o !== 32'h0001_0000) begin
            n_err++;
            $display("FAIL b2b_first: valid=%b addr=%h, expected valid=1 addr=00010000", request_valid_o, addr_request_o);
        end
        addr_request_i = 32'h0001_0080;
        @(negedge clk_i);
        n_cmp++;
        if (request_valid_o !== 1'b0 || mem_req_o !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_gap: valid=%b req=%b, expected valid=0 req=0", request_valid_o, mem_req_o);
        end
        @(negedge clk_i);
        serve_fill(32'h0001_0080, 32'h4400_0000, 0, 0, WORDS - 1);
        n_cmp++;
        if (request_valid_o !== 1'b1 || addr_request_o !== 32'h0001_0080 || data_request_o !== make_block(32'h4400_0000)) begin
            n_err++;
            $display("FAIL b2b_second: valid=%b addr=%h w0=%h, expected valid=1 addr=00010080 w0=44000000",
                     request_valid_o, addr_request_o, data_request_o[31:0]);
        end
        request_i = 1'b0;
        @(negedge clk_i);
        n_cmp++;
        if (request_valid_o !== 1'b0 || mem_req_o !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_end: valid=%b req=%b, expected valid=0 req=0", request_valid_o, mem_req_o);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_evict();
        test_priority();
        test_reset_mid_fill();
        test_ignore_inputs();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cache_dma_responder.md
Name: cache_dma_responder

Overview:
Memory-side responder for the cache hierarchy's DMA interface. It services block-fill requests and dirty-block evictions from the last-level cache. Each 512-bit block is serialised into word-wide transfers on a simple req/ack memory port. For fills, the returned words are reassembled and handed back to the cache as one block with a single-cycle valid pulse.

Parameters:
BLOCK_BITS, 512, cache block width in bits; must be a multiple of WORD_BITS.
WORD_BITS, 32, memory port data width in bits.
WORDS (localparam), BLOCK_BITS/WORD_BITS = 16, words per block; beat counter is clog2(WORDS) bits.

Ports:
clk_i  in  1  clock, all state rising-edge.
rst_i  in  1  reset, asynchronous, active-high.
request_i  in  1  cache fill request; held high until request_valid_o is seen.
addr_request_i  in  32  byte address of requested block.
data_request_o  out  BLOCK_BITS  filled block; word k at bits [k*32 +: 32].
addr_request_o  out  32  block-aligned address of the filled block.
request_valid_o  out  1  one-cycle pulse: data_request_o/addr_request_o valid.
evict_req_i  in  1  cache eviction request; held high until evict_ack_o is seen.
data_evict_i  in  BLOCK_BITS  block being evicted.
addr_evict_i  in  32  byte address of evicted block.
evict_ack_o  out  1  one-cycle pulse: eviction fully written to memory.
mem_req_o  out  1  memory word request.
mem_we_o  out  1  1 = write, 0 = read.
mem_addr_o  out  32  word byte address.
mem_wdata_o  out  WORD_BITS  write data.
mem_rdata_i  in  WORD_BITS  read data; valid in the cycle mem_ack_i=1.
mem_ack_i  in  1  memory accepted/completed the current word.

Behaviour:
- Reset (async): state=IDLE; beat counter=0; all outputs 0, including data_request_o, addr_request_o and the fill buffer.
- States: IDLE, EVICT_WR, EVICT_ACK, FILL_RD, FILL_RESP.
- IDLE, evict_req_i=1:
  - latch data_evict_i and {addr_evict_i[31:6],6'b0}; counter=0; go to EVICT_WR.
  - Evict has priority over a simultaneous request_i, so write-back precedes the fill.
- IDLE, request_i=1 only: latch {addr_request_i[31:6],6'b0}; counter=0; go to FILL_RD.
- EVICT_WR:
  - mem_req_o=1, mem_we_o=1, mem_addr_o=base+{cnt,2'b00}, mem_wdata_o=latched[cnt*32 +: 32].
  - On mem_ack_i: cnt++, or go to EVICT_ACK if cnt==WORDS-1.
  - mem_req_o stays high across beats; best case is one word per cycle.
- EVICT_ACK: evict_ack_o=1 for exactly one cycle, then IDLE.
- FILL_RD:
  - mem_req_o=1, mem_we_o=0, mem_addr_o=base+{cnt,2'b00}.
  - On mem_ack_i: buffer[cnt*32 +: 32]<=mem_rdata_i; cnt++, or go to FILL_RESP after the last beat.
- FILL_RESP: request_valid_o=1 for one cycle; data_request_o/addr_request_o are registered and hold their value until the next FILL_RESP.
- Latency with mem_ack_i tied 1:
  - acceptance at edge 0; beats in cycles 1..16;
  - evict_ack_o or request_valid_o high in cycle 17.
- Inputs are sampled only in IDLE. Changes to request/evict data or address mid-operation are ignored.
- Cache contract: deassert request_i/evict_req_i in the cycle after sampling the pulse. IDLE following a response therefore sees them low.
- mem_ack_i while mem_req_o=0 is ignored.
- Addresses wrap within the 64-byte block only; low 6 address bits of inputs are discarded.
- Reset mid-operation: transfer aborted, no ack/valid issued, mem_req_o drops immediately. The next request restarts at word 0.

Test Plan:
1. Fill, ack tied 1, mem returns 0xA000_0000+k for word k, addr_request_i=0x0000_1234 -> mem_addr_o 0x1200..0x123C in order, mem_we_o=0; request_valid_o one cycle at cycle 17; addr_request_o=0x00001200; data_request_o[31:0]=0xA0000000, [511:480]=0xA000000F.
2. Evict of block word k=0xE000_0000+k at 0x0000_4040, ack after 3-cycle wait per word -> 16 writes, mem_addr_o 0x4040..0x407C, mem_wdata_o matches; single evict_ack_o pulse one cycle after 16th ack.
3. evict_req_i and request_i asserted same cycle -> all 16 writes complete and evict_ack_o pulses before first read; request_valid_o follows.
4. Reset asserted mid-fill after word 5 -> all outputs 0 immediately, no request_valid_o; new fill reads from word 0.
5. mem_ack_i pulsed in IDLE, and addr_request_i changed during FILL_RD -> no state change in IDLE; fill uses originally latched address.
6. Back-to-back fills (request_i reasserted cycle after valid) -> second fill starts in the next IDLE cycle, responses correct, no duplicated valid pulse.
